// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

    localparam int ADDR_W_DEF  = 32;
    localparam int INSTR_W_DEF = 32;

    // addi x0,x0,0 : bubble placed in IF/ID whenever it holds no real instruction
    localparam logic [31:0] IF_NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register. Priority: flush > load > stall-hold > bubble.
module if_id_reg
    import if_pkg::*;
#(
    parameter int                 ADDR_W    = ADDR_W_DEF,
    parameter int                 INSTR_W   = INSTR_W_DEF,
    parameter logic [INSTR_W-1:0] NOP_INSTR = IF_NOP_INSTR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               load,
    input  logic               stall,
    input  logic [ADDR_W-1:0]  load_pc,
    input  logic [INSTR_W-1:0] load_instr,
    output logic [ADDR_W-1:0]  pc,
    output logic [INSTR_W-1:0] instr,
    output logic               valid
);

    logic [ADDR_W-1:0]  pc_reg;
    logic [INSTR_W-1:0] instr_reg;
    logic               valid_reg;

    // The PC field is left untouched on flush/bubble; only valid and the word matter.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg    <= '0;
            instr_reg <= NOP_INSTR;
            valid_reg <= 1'b0;
        end else if (flush) begin
            instr_reg <= NOP_INSTR;
            valid_reg <= 1'b0;
        end else if (load) begin
            pc_reg    <= load_pc;
            instr_reg <= load_instr;
            valid_reg <= 1'b1;
        end else if (!stall) begin
            instr_reg <= NOP_INSTR;
            valid_reg <= 1'b0;
        end
    end

    assign pc    = pc_reg;
    assign instr = instr_reg;
    assign valid = valid_reg;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: takes one PC at a time, fetches it over req/ack + rvalid,
// and loads the returned word into IF/ID, handling decode stalls and branch flushes.
module if_fetch_stage
    import if_pkg::*;
#(
    parameter int                 ADDR_W    = ADDR_W_DEF,
    parameter int                 INSTR_W   = INSTR_W_DEF,
    parameter logic [INSTR_W-1:0] NOP_INSTR = IF_NOP_INSTR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  pc_in,
    input  logic               pc_valid,
    output logic               pc_ready,
    input  logic               branch,
    input  logic               ALU_zero,
    input  logic               id_stall,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0]  if_id_pc,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic               if_id_valid,
    output logic               fetch_misalign
);

    fetch_state_t       state_reg;
    logic [ADDR_W-1:0]  pc_q_reg;
    logic [ADDR_W-1:0]  hold_pc_reg;
    logic [INSTR_W-1:0] hold_instr_reg;
    logic               misalign_reg;

    logic               flush;
    logic               aligned;
    logic               idle_offer;
    logic               misalign_drop;
    logic               wait_load;
    logic               hold_load;
    logic               id_load;
    logic [ADDR_W-1:0]  id_load_pc;
    logic [INSTR_W-1:0] id_load_instr;

    assign flush         = branch & ALU_zero;
    assign aligned       = (pc_in[1:0] == 2'b00);
    assign idle_offer    = !rst && (state_reg == IDLE) && pc_valid && !flush;
    assign misalign_drop = idle_offer && !aligned;

    assign imem_req  = idle_offer && aligned;
    assign imem_addr = pc_in;
    // A misaligned PC is consumed without touching memory.
    assign pc_ready  = (imem_req && imem_ack) || misalign_drop;

    // Load straight from memory if IF/ID is empty or draining, else park in HOLD.
    assign wait_load = (state_reg == WAIT) && imem_rvalid && !flush &&
                       (!if_id_valid || !id_stall);
    assign hold_load = (state_reg == HOLD) && !flush && !id_stall;
    assign id_load   = wait_load || hold_load;

    assign id_load_pc    = (state_reg == HOLD) ? hold_pc_reg    : pc_q_reg;
    assign id_load_instr = (state_reg == HOLD) ? hold_instr_reg : imem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            pc_q_reg       <= '0;
            hold_pc_reg    <= '0;
            hold_instr_reg <= NOP_INSTR;
            misalign_reg   <= 1'b0;
        end else begin
            misalign_reg <= misalign_drop;
            unique case (state_reg)
                IDLE: begin
                    if (imem_req && imem_ack) begin
                        pc_q_reg  <= pc_in;
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    if (flush) begin
                        state_reg <= imem_rvalid ? IDLE : DROP;
                    end else if (imem_rvalid) begin
                        if (wait_load) begin
                            state_reg <= IDLE;
                        end else begin
                            hold_pc_reg    <= pc_q_reg;
                            hold_instr_reg <= imem_rdata;
                            state_reg      <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (flush || !id_stall) begin
                        hold_pc_reg    <= '0;
                        hold_instr_reg <= NOP_INSTR;
                        state_reg      <= IDLE;
                    end
                end
                DROP: begin
                    if (imem_rvalid) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign fetch_misalign = misalign_reg;

    if_id_reg #(
        .ADDR_W    (ADDR_W),
        .INSTR_W   (INSTR_W),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .load       (id_load),
        .stall      (id_stall),
        .load_pc    (id_load_pc),
        .load_instr (id_load_instr),
        .pc         (if_id_pc),
        .instr      (if_id_instr),
        .valid      (if_id_valid)
    );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: directed fetch sequences push expected IF/ID
// contents; a monitor pops and compares each new instruction that appears in IF/ID.
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in;
    logic        pc_valid;
    logic        pc_ready;
    logic        branch;
    logic        ALU_zero;
    logic        id_stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        fetch_misalign;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    if_fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .pc_in          (pc_in),
        .pc_valid       (pc_valid),
        .pc_ready       (pc_ready),
        .branch         (branch),
        .ALU_zero       (ALU_zero),
        .id_stall       (id_stall),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .if_id_pc       (if_id_pc),
        .if_id_instr    (if_id_instr),
        .if_id_valid    (if_id_valid),
        .fetch_misalign (fetch_misalign)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] instr);
        exp_t e;
        e.pc    = pc;
        e.instr = instr;
        sb.push_back(e);
    endtask

    // Monitor: a new IF/ID instruction is valid rising or valid contents changing.
    logic        prev_valid = 1'b0;
    logic [31:0] prev_pc    = '0;
    logic [31:0] prev_instr = '0;
    initial begin
        forever begin
            @(negedge clk);
            if (if_id_valid && (!prev_valid || if_id_pc != prev_pc || if_id_instr != prev_instr)) begin
                if (sb.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_ifid: got pc 0x%08h instr 0x%08h, scoreboard empty",
                             if_id_pc, if_id_instr);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("ifid_pc", if_id_pc, e.pc);
                    check("ifid_instr", if_id_instr, e.instr);
                end
            end
            prev_valid = if_id_valid;
            prev_pc    = if_id_pc;
            prev_instr = if_id_instr;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; pc_in = '0; pc_valid = 1'b1; branch = 1'b0; ALU_zero = 1'b0;
        id_stall = 1'b0; imem_ack = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
        tick(); tick();
        // reset state, with a fetch offered while rst is high
        check("rst_valid", {31'b0, if_id_valid}, 32'd0);
        check("rst_pc", if_id_pc, 32'h0);
        check("rst_instr", if_id_instr, NOP);
        check("rst_misalign", {31'b0, fetch_misalign}, 32'd0);
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_ready", {31'b0, pc_ready}, 32'd0);
        rst = 1'b0;

        // 1: simple fetch of 0x0
        #1;
        check("t1_req", {31'b0, imem_req}, 32'd1);
        check("t1_addr", imem_addr, 32'h0);
        check("t1_ready", {31'b0, pc_ready}, 32'd1);
        tick();
        pc_valid = 1'b0; imem_ack = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093; push(32'h0, 32'h0050_0093);
        #1;
        check("t1_wait_req", {31'b0, imem_req}, 32'd0);
        check("t1_wait_ready", {31'b0, pc_ready}, 32'd0);
        tick();
        imem_rvalid = 1'b0;
        check("t1_loaded", {31'b0, if_id_valid}, 32'd1);
        tick();
        check("t1_bubble_valid", {31'b0, if_id_valid}, 32'd0);
        check("t1_bubble_instr", if_id_instr, NOP);

        // 2: ack withheld for 3 cycles
        pc_in = 32'h4; pc_valid = 1'b1; imem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t2_req", {31'b0, imem_req}, 32'd1);
            check("t2_noready", {31'b0, pc_ready}, 32'd0);
            tick();
        end
        imem_ack = 1'b1;
        #1;
        check("t2_ready", {31'b0, pc_ready}, 32'd1);
        tick();
        pc_valid = 1'b0; imem_ack = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'h00A0_0113; push(32'h4, 32'h00A0_0113);
        tick();
        imem_rvalid = 1'b0;

        // 3: stall while 0xC returns; it waits in HOLD
        pc_in = 32'h8; pc_valid = 1'b1; imem_ack = 1'b1;
        tick();
        pc_valid = 1'b0; imem_ack = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'h0000_0513; push(32'h8, 32'h0000_0513);
        tick();
        imem_rvalid = 1'b0; id_stall = 1'b1;
        pc_in = 32'hC; pc_valid = 1'b1; imem_ack = 1'b1;
        tick();
        pc_valid = 1'b0; imem_ack = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'h0010_0593; push(32'hC, 32'h0010_0593);
        tick();
        imem_rvalid = 1'b0;
        check("t3_keep_pc", if_id_pc, 32'h8);
        check("t3_keep_valid", {31'b0, if_id_valid}, 32'd1);
        tick();
        check("t3_keep_pc2", if_id_pc, 32'h8);
        id_stall = 1'b0;
        tick();
        check("t3_release_pc", if_id_pc, 32'hC);
        id_stall = 1'b1;
        pc_in = 32'h10; pc_valid = 1'b1; imem_ack = 1'b0;
        #1;
        check("t3_idle_req", {31'b0, imem_req}, 32'd1);

        // 4: flush while WAIT for 0x10; late response is dropped
        imem_ack = 1'b1;
        tick();
        pc_valid = 1'b0; imem_ack = 1'b0;
        branch = 1'b1; ALU_zero = 1'b1;
        tick();
        branch = 1'b0; ALU_zero = 1'b0;
        check("t4_flush_valid", {31'b0, if_id_valid}, 32'd0);
        check("t4_flush_instr", if_id_instr, NOP);
        pc_in = 32'h20; pc_valid = 1'b1; imem_ack = 1'b1;
        #1;
        check("t4_drop_req", {31'b0, imem_req}, 32'd0);
        check("t4_drop_ready", {31'b0, pc_ready}, 32'd0);
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        check("t4_refetch_req", {31'b0, imem_req}, 32'd1);
        check("t4_refetch_addr", imem_addr, 32'h20);
        tick();
        pc_valid = 1'b0; imem_ack = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'h0020_8193; push(32'h20, 32'h0020_8193);
        tick();
        imem_rvalid = 1'b0;
        // same situation with ALU_zero=0: no flush
        pc_in = 32'h24; pc_valid = 1'b1; imem_ack = 1'b1;
        tick();
        pc_valid = 1'b0; imem_ack = 1'b0;
        branch = 1'b1; ALU_zero = 1'b0;
        tick();
        check("t4_noflush_valid", {31'b0, if_id_valid}, 32'd1);
        id_stall = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'h0030_8213; push(32'h24, 32'h0030_8213);
        tick();
        imem_rvalid = 1'b0; branch = 1'b0; id_stall = 1'b1;

        // 5: flush + stall together while in HOLD
        pc_in = 32'h28; pc_valid = 1'b1; imem_ack = 1'b1;
        tick();
        pc_valid = 1'b0; imem_ack = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'h0041_8293;
        tick();
        imem_rvalid = 1'b0;
        check("t5_hold_pc", if_id_pc, 32'h24);
        branch = 1'b1; ALU_zero = 1'b1;
        tick();
        branch = 1'b0; ALU_zero = 1'b0;
        check("t5_flush_valid", {31'b0, if_id_valid}, 32'd0);
        check("t5_flush_instr", if_id_instr, NOP);
        pc_in = 32'h30; pc_valid = 1'b1;
        #1;
        check("t5_idle_req", {31'b0, imem_req}, 32'd1);
        id_stall = 1'b0;
        tick();
        check("t5_no_reload", {31'b0, if_id_valid}, 32'd0);

        // 6: misaligned PC, then reset in the middle of WAIT
        pc_in = 32'h6;
        #1;
        check("t6_mis_req", {31'b0, imem_req}, 32'd0);
        check("t6_mis_ready", {31'b0, pc_ready}, 32'd1);
        check("t6_mis_pre", {31'b0, fetch_misalign}, 32'd0);
        tick();
        pc_valid = 1'b0;
        check("t6_mis_pulse", {31'b0, fetch_misalign}, 32'd1);
        tick();
        check("t6_mis_end", {31'b0, fetch_misalign}, 32'd0);
        pc_in = 32'h40; pc_valid = 1'b1; imem_ack = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        check("t6_rst_pc", if_id_pc, 32'h0);
        check("t6_rst_instr", if_id_instr, NOP);
        check("t6_rst_req", {31'b0, imem_req}, 32'd0);
        rst = 1'b0; imem_ack = 1'b0;
        #1;
        check("t6_idle_req", {31'b0, imem_req}, 32'd1);
        pc_valid = 1'b0;
        tick(); tick();

        check("sb_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
